// File: rtl/bram_sample_streamer.sv
// BRAM playback fetch stage: one stereo word per audio frame tick,
// volume-shifted and streamed as left/right 24-bit AXI-Stream beats.
module bram_sample_streamer #(
  parameter int RAM_DEPTH = 65278,
  parameter int FS_DIV    = 512,
  parameter int ADDR_W    = 16,
  parameter int BRAM_LAT  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [3:0]        vol,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  output logic              bram_regce,
  input  logic [31:0]       bram_dout,
  output logic [23:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              overrun
);

  localparam int CW = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
  localparam int LW = $clog2(BRAM_LAT + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_TICK = 3'd1;
  localparam logic [2:0] FETCH     = 3'd2;
  localparam logic [2:0] SEND_L    = 3'd3;
  localparam logic [2:0] SEND_R    = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lat;
  logic [23:0]   right_q;
  logic          tick;
  logic          hs;
  logic          last_lat;

  assign tick     = enable && (cnt == CW'(FS_DIV - 1));
  assign hs       = m_axis_tvalid && m_axis_tready;
  assign last_lat = (lat == LW'(BRAM_LAT - 1));

  // Left-justify to 24 bits, then attenuate keeping the sign.
  function automatic logic [23:0] scale(
    input logic [15:0] s,
    input logic [3:0]  sh
  );
    logic signed [23:0] w;
    w = {s, 8'h00};
    return w >>> sh;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (tick && state != WAIT_TICK) begin
      overrun <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      lat           <= '0;
      bram_addr     <= '0;
      bram_en       <= 1'b0;
      bram_regce    <= 1'b0;
      right_q       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (!enable) begin
            state <= IDLE;
          end else if (tick) begin
            state      <= FETCH;
            lat        <= '0;
            bram_en    <= 1'b1;
            bram_regce <= 1'b1;
          end
        end
        FETCH: begin
          if (last_lat) begin
            bram_en       <= 1'b0;
            bram_regce    <= 1'b0;
            m_axis_tdata  <= scale(bram_dout[31:16], vol);
            right_q       <= scale(bram_dout[15:0], vol);
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            state         <= SEND_L;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        SEND_L: begin
          if (hs) begin
            m_axis_tdata <= right_q;
            m_axis_tlast <= 1'b1;
            state        <= SEND_R;
          end
        end
        SEND_R: begin
          if (hs) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            state         <= WAIT_TICK;
            if (bram_addr == ADDR_W'(RAM_DEPTH)) begin
              bram_addr <= '0;
            end else begin
              bram_addr <= bram_addr + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_sample_streamer.sv
// Directed bench for bram_sample_streamer: timing, data scaling,
// backpressure/overrun, address wrap, async reset and enable drop.
module tb_bram_sample_streamer;

  localparam int FS  = 16;
  localparam int RD  = 4;
  localparam int AW  = 16;
  localparam int LAT = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [3:0]    vol;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic          bram_regce;
  logic [31:0]   bram_dout;
  logic [23:0]   tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  logic bad_addr  = 1'b0;
  logic prot_err  = 1'b0;
  logic p_v       = 1'b0;
  logic p_hs      = 1'b0;
  logic p_rst     = 1'b1;
  logic [23:0] p_data = '0;
  logic stable_bad;
  logic en_seen;

  always #5 clock = ~clock;

  bram_sample_streamer #(
    .RAM_DEPTH(RD),
    .FS_DIV(FS),
    .ADDR_W(AW),
    .BRAM_LAT(LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .vol(vol),
    .bram_addr(bram_addr),
    .bram_en(bram_en),
    .bram_regce(bram_regce),
    .bram_dout(bram_dout),
    .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tlast(tlast),
    .m_axis_tready(tready),
    .overrun(overrun)
  );

  // Address range and AXI hold rules watched on every edge.
  always @(posedge clock) begin
    if (32'(bram_addr) > RD) bad_addr <= 1'b1;
    if (!reset && !p_rst && p_v && !p_hs) begin
      if (tvalid !== 1'b1 || tdata !== p_data) prot_err <= 1'b1;
    end
    p_v    <= tvalid;
    p_hs   <= tvalid && tready;
    p_data <= tdata;
    p_rst  <= reset;
  end

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (tvalid !== 1'b1 && n < 4 * FS) begin
      step();
      n++;
    end
    chk({tag, "_wait"}, 32'(tvalid), 32'd1);
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (bram_en !== 1'b1 && n < 4 * FS) begin
      step();
      n++;
    end
    chk({tag, "_wait"}, 32'(bram_en), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    vol       = 4'd0;
    tready    = 1'b1;
    bram_dout = 32'h1234_8000;
    step();
    step();

    // reset state
    chk("rst_addr", 32'(bram_addr), 32'd0);
    chk("rst_en", 32'(bram_en), 32'd0);
    chk("rst_regce", 32'(bram_regce), 32'd0);
    chk("rst_valid", 32'(tvalid), 32'd0);
    chk("rst_last", 32'(tlast), 32'd0);
    chk("rst_data", 32'(tdata), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);

    // first frame, vol=0
    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < FS - 1; i++) step();
    chk("f1_en_early", 32'(bram_en), 32'd0);
    step();
    chk("f1_en", 32'(bram_en), 32'd1);
    chk("f1_regce", 32'(bram_regce), 32'd1);
    chk("f1_addr", 32'(bram_addr), 32'd0);
    step();
    chk("f1_lat", 32'(tvalid), 32'd0);
    step();
    chk("f1_lv", 32'(tvalid), 32'd1);
    chk("f1_ld", 32'(tdata), 32'h123400);
    chk("f1_ll", 32'(tlast), 32'd0);
    step();
    chk("f1_rv", 32'(tvalid), 32'd1);
    chk("f1_rd", 32'(tdata), 32'h800000);
    chk("f1_rl", 32'(tlast), 32'd1);
    step();
    chk("f1_end", 32'(tvalid), 32'd0);
    chk("f1_addr1", 32'(bram_addr), 32'd1);

    // vol=4 sign extension, mid-frame vol change ignored
    bram_dout = 32'h8000_7FFF;
    vol       = 4'd4;
    wait_valid("f2");
    chk("f2_ld", 32'(tdata), 32'hF80000);
    chk("f2_addr", 32'(bram_addr), 32'd1);
    vol = 4'd0;
    step();
    chk("f2_rd", 32'(tdata), 32'h07FFF0);
    chk("f2_rl", 32'(tlast), 32'd1);
    step();
    chk("f2_addr2", 32'(bram_addr), 32'd2);

    // backpressure across several ticks
    tready    = 1'b0;
    bram_dout = 32'hFFFF_0001;
    vol       = 4'd1;
    wait_valid("bp");
    chk("bp_ld", 32'(tdata), 32'hFFFF80);
    stable_bad = 1'b0;
    en_seen    = 1'b0;
    for (int i = 0; i < 3 * FS; i++) begin
      step();
      if (tvalid !== 1'b1 || tdata !== 24'hFFFF80 || tlast !== 1'b0)
        stable_bad = 1'b1;
      if (bram_en !== 1'b0) en_seen = 1'b1;
    end
    chk("bp_stable", 32'(stable_bad), 32'd0);
    chk("bp_nofetch", 32'(en_seen), 32'd0);
    chk("bp_ovr", 32'(overrun), 32'd1);
    tready = 1'b1;
    step();
    chk("bp_rd", 32'(tdata), 32'h000080);
    chk("bp_rl", 32'(tlast), 32'd1);
    step();
    chk("bp_addr3", 32'(bram_addr), 32'd3);
    wait_valid("bp_next");
    chk("bp_next_addr", 32'(bram_addr), 32'd3);
    step();
    step();
    chk("bp_addr4", 32'(bram_addr), 32'd4);

    // address wrap at RAM_DEPTH
    wait_valid("wrap");
    chk("wrap_addr", 32'(bram_addr), 32'd4);
    step();
    step();
    chk("wrap_addr0", 32'(bram_addr), 32'd0);
    wait_valid("pre");
    step();
    step();
    chk("pre_addr1", 32'(bram_addr), 32'd1);

    // async reset during SEND_R with tready low
    wait_valid("rs");
    step();
    tready = 1'b0;
    chk("rs_last", 32'(tlast), 32'd1);
    step();
    chk("rs_hold", 32'(tvalid), 32'd1);
    chk("rs_ovr_pre", 32'(overrun), 32'd1);
    reset = 1'b1;
    #1;
    chk("rs_valid", 32'(tvalid), 32'd0);
    chk("rs_addr", 32'(bram_addr), 32'd0);
    chk("rs_ovr", 32'(overrun), 32'd0);
    chk("rs_tlast", 32'(tlast), 32'd0);
    @(negedge clock);
    step();
    reset     = 1'b0;
    tready    = 1'b1;
    bram_dout = 32'h0100_FF00;
    vol       = 4'd8;
    for (int i = 0; i < FS - 1; i++) step();
    chk("rs_en_early", 32'(bram_en), 32'd0);
    step();
    chk("rs_en", 32'(bram_en), 32'd1);
    chk("rs_faddr", 32'(bram_addr), 32'd0);
    step();
    step();
    chk("rs_ld", 32'(tdata), 32'h000100);
    step();
    chk("rs_rd", 32'(tdata), 32'hFFFF00);
    step();
    chk("rs_addr1", 32'(bram_addr), 32'd1);

    // enable dropped during FETCH
    bram_dout = 32'h0002_FFFE;
    vol       = 4'd0;
    wait_en("en");
    step();
    enable = 1'b0;
    step();
    chk("en_ld", 32'(tdata), 32'h000200);
    chk("en_lv", 32'(tvalid), 32'd1);
    step();
    chk("en_rd", 32'(tdata), 32'hFFFE00);
    step();
    chk("en_addr2", 32'(bram_addr), 32'd2);
    en_seen = 1'b0;
    for (int i = 0; i < 3 * FS; i++) begin
      step();
      if (bram_en !== 1'b0 || tvalid !== 1'b0) en_seen = 1'b1;
    end
    chk("en_quiet", 32'(en_seen), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < FS - 2; i++) step();
    chk("en_resume_early", 32'(bram_en), 32'd0);
    step();
    chk("en_resume", 32'(bram_en), 32'd1);
    chk("en_resume_addr", 32'(bram_addr), 32'd2);
    step();
    step();
    step();
    step();

    chk("addr_range", 32'(bad_addr), 32'd0);
    chk("axi_hold", 32'(prot_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_sample_streamer.md
Name: bram_sample_streamer

Overview:
- Playback fetch stage between the sample BRAM and the I2S transmitter's AXI-Stream input.
- Each audio frame tick, it reads one 32-bit stereo word from BRAM and waits out the BRAM read latency.
- It applies a volume shift, then emits two 24-bit AXI-Stream beats: left first, then right with tlast.
- It replaces the free-running address/fs counter logic, giving the transmitter a proper valid/ready interface.

Parameters:
- RAM_DEPTH, 65278: last valid BRAM address; address wraps to 0 after it.
- FS_DIV, 512: clock cycles per audio frame (22.591 MHz / 44.1 kHz); the tick period is exactly FS_DIV.
- ADDR_W, 16: BRAM address width.
- BRAM_LAT, 2: cycles from address/enable to valid douta (2 with regcea output register).

Ports:
- clock, in, 1: 22.591 MHz PLL clock.
- reset, in, 1: asynchronous, active-high reset.
- enable, in, 1: run control (PLL locked); low = hold state, no ticks counted.
- vol, in, 4: attenuation, arithmetic right shift of 0..15.
- bram_addr, out, ADDR_W: BRAM address.
- bram_en, out, 1: BRAM enable.
- bram_regce, out, 1: BRAM output register enable.
- bram_dout, in, 32: BRAM read data; [31:16] is left, [15:0] is right, both signed 16-bit.
- m_axis_tdata, out, 24: sample.
- m_axis_tvalid, out, 1: sample valid.
- m_axis_tlast, out, 1: high on the right-channel beat.
- m_axis_tready, in, 1: downstream ready.
- overrun, out, 1: sticky flag; a tick arrived before the previous frame finished.

Behaviour:
Reset values (asynchronous, on reset high):
- bram_addr=0, bram_en=0, bram_regce=0.
- tvalid=0, tlast=0, tdata=0.
- overrun=0, tick counter=0, state=IDLE.

Tick counter:
- Counts 0..FS_DIV-1 while enable=1; tick pulses for one cycle when the count reaches FS_DIV-1, then wraps to 0.
- The counter holds while enable=0.

State machine:
- IDLE: bram_en=0. Goes to WAIT_TICK when enable=1.
- WAIT_TICK: on tick, go to FETCH with bram_en=1 and bram_regce=1 for the fetch. If enable=0, go to IDLE.
- FETCH: waits BRAM_LAT cycles, counted from the first FETCH cycle, with bram_addr held. On the last cycle, capture bram_dout and vol into internal registers, then go to SEND_L.
- SEND_L: tvalid=1, tlast=0, tdata=left.
  - On tvalid & tready, go to SEND_R.
- SEND_R: tvalid=1, tlast=1, tdata=right.
  - On tvalid & tready, advance the address (RAM_DEPTH wraps to 0, else +1) and go to WAIT_TICK.

Data path:
- sample24 = {s16, 8'h00}.
- tdata = sample24 >>> vol (arithmetic, sign preserved).
- vol is captured once per frame, so a mid-frame vol change affects only the next frame.

Handshake:
- tdata and tlast stay stable while tvalid=1 and tready=0.
- tvalid never drops without a handshake, except on reset.

Overrun:
- A tick in any state other than WAIT_TICK is dropped and sets overrun (sticky until reset).
- The current frame completes normally; the next fetch waits for the following tick.
- The address is not skipped.

Enable low mid-frame:
- The current frame completes (no AXI protocol violation).
- The block then returns to IDLE; the tick counter stays frozen at its value.

Reset mid-operation:
- Immediately forces all reset values.
- Any in-flight beat is abandoned and the address returns to 0.

Simultaneous events:
- tick and the final SEND_R handshake in the same cycle: the tick counts as an overrun (state is not WAIT_TICK).

Test Plan:
- reset, then enable=1, tready=1, bram_dout=32'h1234_8000, vol=0 -> first fetch at cycle FS_DIV; beats are tdata=24'h123400 (tlast=0) then 24'h800000 (tlast=1); bram_addr goes 0->1.
- vol=4, word 32'h8000_7FFF -> left 24'hF80000, right 24'h07FFF0; check sign extension.
- bram_addr preloaded to RAM_DEPTH via a run of 65279 frames (or a forced start point) -> after the frame, bram_addr=0; no address 65279 is ever issued.
- tready held low 3*FS_DIV cycles during SEND_L -> tdata/tvalid stable throughout; overrun=1; after release, exactly one frame is emitted per subsequent tick and the address increments by 1.
- reset asserted during SEND_R with tready=0 -> tvalid=0 and bram_addr=0 in the same cycle, overrun cleared; after release, normal playback from address 0.
- enable dropped during FETCH -> both beats still delivered; no further bram_en pulses; the tick counter resumes from its held value when enable returns.
